// File: rtl/vote_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vote_capture_ctrl (with helper encoder16to4)
//  Purpose  : Arms one ballot per officer enable, qualifies a stable one-hot
//             candidate press and commits one saturating vote per ballot.
//  Revision : 1.0  initial release
// ============================================================================

module encoder16to4 (
    input  logic [15:0] i_btn,
    output logic [3:0]  o_idx,
    output logic        o_valid
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (i_btn[i]) o_idx = 4'(i);
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign o_valid = (i_btn != 16'd0) && ((i_btn & (i_btn - 16'd1)) == 16'd0);

endmodule

module vote_capture_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TOT_W       = 12,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ballot_en,
    input  logic [15:0]      cand_btn,
    input  logic [3:0]       rd_sel,
    output logic             ballot_ready,
    output logic             vote_done,
    output logic [3:0]       vote_idx,
    output logic             invalid,
    output logic [CNT_W-1:0] rd_count,
    output logic [TOT_W-1:0] total_votes
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ARMED   = 3'd1;
    localparam logic [2:0] c_ST_CAPTURE = 3'd2;
    localparam logic [2:0] c_ST_COMMIT  = 3'd3;
    localparam logic [2:0] c_ST_RELEASE = 3'd4;
    localparam logic [2:0] c_ST_REJECT  = 3'd5;

    localparam logic [7:0]       c_HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [TOT_W-1:0] c_TOT_ONE   = TOT_W'(1);

    logic [2:0]       r_state;
    logic [15:0]      r_pat;
    logic [3:0]       r_idx;
    logic [7:0]       r_hold_cnt;
    logic [CNT_W-1:0] r_tally [16];
    logic [TOT_W-1:0] r_total;
    logic             r_ballot_ready;
    logic             r_vote_done;
    logic             r_invalid;
    logic [3:0]       r_vote_idx;

    logic [3:0]       w_enc_idx;
    logic             w_enc_valid;

    encoder16to4 u_enc (
        .i_btn   (cand_btn),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_pat          <= '0;
            r_idx          <= '0;
            r_hold_cnt     <= '0;
            r_total        <= '0;
            r_ballot_ready <= 1'b0;
            r_vote_done    <= 1'b0;
            r_invalid      <= 1'b0;
            r_vote_idx     <= '0;
            for (int i = 0; i < 16; i++) r_tally[i] <= '0;
        end else begin
            r_vote_done <= 1'b0;
            r_invalid   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (ballot_en) begin
                        r_state        <= c_ST_ARMED;
                        r_ballot_ready <= 1'b1;
                    end
                end
                c_ST_ARMED: begin
                    if (w_enc_valid) begin
                        r_state        <= c_ST_CAPTURE;
                        r_pat          <= cand_btn;
                        r_idx          <= w_enc_idx;
                        r_hold_cnt     <= 8'd1;
                        r_ballot_ready <= 1'b0;
                    end else if (cand_btn != 16'd0) begin
                        r_state        <= c_ST_REJECT;
                        r_invalid      <= 1'b1;
                        r_ballot_ready <= 1'b0;
                    end
                end
                c_ST_CAPTURE: begin
                    if (cand_btn == r_pat) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state     <= c_ST_COMMIT;
                            r_vote_done <= 1'b1;
                            r_vote_idx  <= r_idx;
                            if (r_tally[r_idx] != '1) r_tally[r_idx] <= r_tally[r_idx] + c_CNT_ONE;
                            if (r_total != '1)        r_total <= r_total + c_TOT_ONE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 8'd1;
                        end
                    end else begin
                        // Any deviation restarts qualification from the armed state.
                        r_state        <= c_ST_ARMED;
                        r_ballot_ready <= 1'b1;
                    end
                end
                c_ST_COMMIT: begin
                    r_state <= c_ST_RELEASE;
                end
                c_ST_RELEASE: begin
                    if (cand_btn == 16'd0) r_state <= c_ST_IDLE;
                end
                c_ST_REJECT: begin
                    if (cand_btn == 16'd0) begin
                        r_state        <= c_ST_ARMED;
                        r_ballot_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= c_ST_IDLE;
                    r_ballot_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ballot_ready = r_ballot_ready;
    assign vote_done    = r_vote_done;
    assign vote_idx     = r_vote_idx;
    assign invalid      = r_invalid;
    assign rd_count     = r_tally[rd_sel];
    assign total_votes  = r_total;

endmodule
`default_nettype wire

// File: tb/tb_vote_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vote_capture_ctrl
//  Purpose  : Randomized ballot scenarios against a tally-level reference,
//             with an event scoreboard for vote_done / invalid pulses.
//  Revision : 1.0  initial release
// ============================================================================

module tb_vote_capture_ctrl;

    localparam int CNT_W = 2;
    localparam int TOT_W = 4;
    localparam int HOLD  = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int TMAX  = (1 << TOT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             ballot_en;
    logic [15:0]      cand_btn;
    logic [3:0]       rd_sel;
    logic             ballot_ready;
    logic             vote_done;
    logic [3:0]       vote_idx;
    logic             invalid;
    logic [CNT_W-1:0] rd_count;
    logic [TOT_W-1:0] total_votes;

    vote_capture_ctrl #(.CNT_W(CNT_W), .TOT_W(TOT_W), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .ballot_en    (ballot_en),
        .cand_btn     (cand_btn),
        .rd_sel       (rd_sel),
        .ballot_ready (ballot_ready),
        .vote_done    (vote_done),
        .vote_idx     (vote_idx),
        .invalid      (invalid),
        .rd_count     (rd_count),
        .total_votes  (total_votes)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int m_tally [16];
    int m_total = 0;

    typedef struct {
        bit is_vote;
        int at;
        int idx;
        int cnt;
        int tot;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Scoreboard monitor: every pulse must match the oldest expected event.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && (vote_done || invalid)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {30'd0, vote_done, invalid}, 0);
            end else begin
                e = q.pop_front();
                chk("event_kind", vote_done ? 1 : 0, e.is_vote ? 1 : 0);
                chk("event_edge", cyc, e.at);
                if (e.is_vote) chk("vote_idx", vote_idx, e.idx);
                chk("event_rd_count", rd_count, e.cnt);
                chk("event_total", total_votes, e.tot);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vote(input int c, input int at);
        m_tally[c] = sat(m_tally[c] + 1, CMAX);
        m_total    = sat(m_total + 1, TMAX);
        q.push_back('{1'b1, at, c, m_tally[c], m_total});
    endtask

    task automatic push_invalid(input int at);
        q.push_back('{1'b0, at, 0, m_tally[rd_sel], m_total});
    endtask

    task automatic hold(input int k, input bit poke_en);
        for (int j = 0; j < k; j++) begin
            if (poke_en && j == k - 1) ballot_en = 1'b1;
            tick();
            ballot_en = 1'b0;
        end
    endtask

    task automatic arm(input bit with_btn, input logic [15:0] pat);
        ballot_en = 1'b1;
        if (with_btn) cand_btn = pat;
        tick();
        ballot_en = 1'b0;
        chk("ready_armed", ballot_ready, 1);
    endtask

    task automatic release_btn();
        cand_btn = '0;
        tick();
        tick();
        chk("ready_after_vote", ballot_ready, 0);
    endtask

    // From ARMED: press candidate c and hold it long enough to be counted.
    task automatic press_vote(input int c, input int extra, input bit poke);
        int n;
        rd_sel   = 4'(c);
        cand_btn = 16'h1 << c;
        n = cyc;
        push_vote(c, n + HOLD);
        hold(HOLD + extra, poke);
        release_btn();
    endtask

    task automatic no_enable_press(input int c, input int k);
        cand_btn = 16'h1 << c;
        hold(k, 1'b0);
        cand_btn = '0;
        tick();
        chk("ready_no_enable", ballot_ready, 0);
    endtask

    task automatic scen_vote();
        int c = $urandom_range(15);
        bit wb = 1'($urandom_range(1));
        rd_sel = 4'(c);
        arm(wb, 16'h1 << c);
        if (!wb) begin
            repeat ($urandom_range(2)) tick();
            chk("ready_waiting", ballot_ready, 1);
        end
        press_vote(c, $urandom_range(5), 1'($urandom_range(1)));
        if ($urandom_range(1) == 1) no_enable_press($urandom_range(15), HOLD + 6);
    endtask

    task automatic scen_short(input int c, input int k);
        rd_sel = 4'(c);
        arm(1'b0, '0);
        cand_btn = 16'h1 << c;
        hold(k, 1'b0);
        cand_btn = '0;
        tick();
        chk("ready_after_short", ballot_ready, 1);
        press_vote(c, $urandom_range(3), 1'b0);
    endtask

    task automatic scen_double(input logic [15:0] pat, input int c);
        rd_sel = 4'(c);
        arm(1'b0, '0);
        cand_btn = pat;
        push_invalid(cyc + 1);
        tick();
        chk("ready_in_reject", ballot_ready, 0);
        hold($urandom_range(2), 1'b0);
        cand_btn = '0;
        tick();
        chk("ready_after_reject", ballot_ready, 1);
        press_vote(c, $urandom_range(3), 1'b0);
    endtask

    task automatic scen_switch();
        int c = $urandom_range(15);
        int d = (c + 1 + $urandom_range(14)) % 16;
        int n;
        rd_sel = 4'(d);
        arm(1'b0, '0);
        cand_btn = 16'h1 << c;
        hold($urandom_range(1, HOLD - 1), 1'b0);
        cand_btn = 16'h1 << d;
        n = cyc;
        // The mismatch edge returns to ARMED; counting restarts one edge later.
        push_vote(d, n + 1 + HOLD);
        hold(HOLD + 1 + $urandom_range(3), 1'b0);
        release_btn();
    endtask

    function automatic logic [15:0] multi_pat();
        logic [15:0] p;
        do p = 16'($urandom); while ($countones(p) < 2);
        return p;
    endfunction

    task automatic sweep_model(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_sel = 4'(i);
            #1;
            chk(name, rd_count, m_tally[i]);
        end
        chk({name, "_total"}, total_votes, m_total);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) m_tally[i] = 0;
        rst = 1'b1; ballot_en = 1'b0; cand_btn = '0; rd_sel = '0;
        #2;
        sweep_model("reset_rd_count");
        chk("reset_ready", ballot_ready, 0);
        chk("reset_vote_done", vote_done, 0);
        chk("reset_invalid", invalid, 0);
        chk("reset_vote_idx", vote_idx, 0);
        tick();
        @(negedge clk); #2 rst = 1'b0;
        tick();

        // Single vote, then a long hold must not produce a second vote.
        rd_sel = 4'd8;
        arm(1'b0, '0);
        press_vote(8, 20, 1'b0);
        chk("tally8_single", rd_count, 1);
        chk("total_single", total_votes, 1);

        scen_short(2, 3);
        scen_double(16'h0005, 15);
        no_enable_press(1, 10);
        sweep_model("after_directed");

        // Saturation of a 2-bit tally.
        for (int b = 0; b < 4; b++) begin
            rd_sel = 4'd3;
            arm(1'b0, '0);
            press_vote(3, 0, 1'b0);
        end
        rd_sel = 4'd3;
        #1 chk("tally3_saturated", rd_count, 3);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(3))
                0: scen_vote();
                1: scen_short($urandom_range(15), $urandom_range(1, HOLD - 1));
                2: scen_double(multi_pat(), $urandom_range(15));
                default: scen_switch();
            endcase
        end
        tick();
        sweep_model("final_tally");
        chk("queue_drained", q.size(), 0);

        // Asynchronous reset in the middle of a capture.
        rd_sel = 4'd4;
        arm(1'b0, '0);
        cand_btn = 16'h0010;
        hold(2, 1'b0);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) m_tally[i] = 0;
        m_total = 0;
        chk("midreset_ready", ballot_ready, 0);
        chk("midreset_vote_done", vote_done, 0);
        sweep_model("midreset_tally");
        cand_btn = '0;
        @(negedge clk); #2 rst = 1'b0;
        tick();
        chk("post_reset_ready", ballot_ready, 0);
        rd_sel = 4'd5;
        arm(1'b0, '0);
        press_vote(5, 1, 1'b0);
        chk("post_reset_tally5", rd_count, 1);
        chk("post_reset_total", total_votes, 1);
        tick();
        chk("queue_drained_end", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vote_capture_ctrl.md
# vote_capture_ctrl

Ballot sequencer for the 16-candidate voting unit. It arms one ballot per presiding-officer enable and qualifies the candidate button bank through an internal `encoder16to4` instance: exactly one button must be held stable for a programmable number of cycles. It then commits exactly one vote to a per-candidate tally and locks out further input until all buttons are released. It sits between the synchronized button inputs and the result-display/readout logic.

## Interface
- `CNT_W`, 8: width of each per-candidate tally.
- `TOT_W`, 12: width of the total-votes counter.
- `HOLD_CYCLES`, 4: consecutive matching samples required to accept a press. Legal range is 2..255.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  reset, asynchronous and active-high.
- `ballot_en`  in  1  officer enable pulse; arms one ballot.
- `cand_btn`  in  16  candidate buttons, one-hot when valid, already synchronized to `clk`.
- `rd_sel`  in  4  tally readout select.
- `ballot_ready`  out  1  high while a ballot is armed and awaiting a press.
- `vote_done`  out  1  one-cycle pulse when a vote is committed.
- `vote_idx`  out  4  candidate index of the last committed vote. Held until the next commit.
- `invalid`  out  1  one-cycle pulse when a multi-button press is rejected.
- `rd_count`  out  CNT_W  tally of candidate `rd_sel` (combinational read).
- `total_votes`  out  TOT_W  total committed votes.

## Operation
The FSM has six states: IDLE, ARMED, CAPTURE, COMMIT, RELEASE and REJECT.

- **IDLE**
  - `ballot_en`=1 → ARMED.
  - `cand_btn` is ignored.
- **ARMED** (`ballot_ready`=1)
  - `cand_btn`=0 → stay in ARMED.
  - Encoder `valid`=1 → CAPTURE. Latch the pattern and index, and set hold_cnt=1.
  - Nonzero with encoder `valid`=0 (two or more buttons) → REJECT, with `invalid` pulsed for one cycle.
- **CAPTURE**
  - `cand_btn` equals the latched pattern and hold_cnt = HOLD_CYCLES-1 → COMMIT.
  - `cand_btn` equals the latched pattern otherwise → increment hold_cnt.
  - Any mismatch (release, change, or extra button) → ARMED with no vote. A multi-button mismatch does not pulse `invalid`; the next ARMED sample decides the outcome.
- **COMMIT** (one cycle)
  - On the entering edge: tally[idx] and `total_votes` each increment, saturating at all-ones. `vote_idx` is loaded, and `vote_done` is registered high for exactly this cycle.
  - Next edge → RELEASE.
- **RELEASE**
  - Leave for IDLE on the first edge that samples `cand_btn`=0.
  - A new ballot requires a new `ballot_en`.
- **REJECT**
  - Leave for ARMED on the first edge that samples `cand_btn`=0.
  - The ballot stays armed; no vote is consumed.

General rules:
- `ballot_en` is ignored in every state except IDLE; it does not queue.
- When `ballot_en` and a button arrive on the same edge in IDLE, the block enters ARMED only. The button is first sampled on the next edge.
- Saturation: a tally at 2^CNT_W-1 stays there, and `total_votes` at 2^TOT_W-1 stays there. `vote_done` still pulses in both cases.
- `rd_count` reflects the updated tally in the COMMIT cycle.

## Timing
- Reset values:
  - State IDLE; all tallies, `total_votes` and hold_cnt are 0.
  - `ballot_ready`=0, `vote_done`=0, `invalid`=0, `vote_idx`=0.
  - `rd_count`=0 for every `rd_sel`.
- Reset mid-operation, in any state, returns the block to IDLE immediately. Tallies are cleared and no `vote_done` is issued.
- Latency: a press first sampled at edge t and matching at edges t..t+HOLD_CYCLES-1 enters COMMIT at edge t+HOLD_CYCLES-1. `vote_done` is then high from that edge to the next one.
- `invalid` is high for the single cycle following the ARMED edge that sampled the multi-button pattern.
- `ballot_ready` is a Moore output of ARMED. It is low in CAPTURE, COMMIT, RELEASE and REJECT.
- The minimum ballot-to-ballot spacing is HOLD_CYCLES+3 edges.

## Test plan
- **Reset readout:** assert `rst`, then sweep `rd_sel` 0..15 → `rd_count`=0, `total_votes`=0, `ballot_ready`=0.
- **Single vote:** `ballot_en` pulse, then hold `cand_btn`=16'h0100 for 4 edges (HOLD_CYCLES=4) → one `vote_done` with `vote_idx`=8. Tally 8 reads 1, `total_votes`=1. Holding the button another 20 cycles produces no second vote.
- **Short press:** `ballot_en`, then 16'h0004 for 3 edges, then 0 → no `vote_done`, `ballot_ready` stays 1. Then 16'h0004 for 4 edges → tally 2 reads 1.
- **Double press:** `ballot_en`, then 16'h0005 → `invalid` high for 1 cycle, no count change. Release, then 16'h8000 for 4 edges → tally 15 reads 1.
- **No enable:** with no `ballot_en`, hold 16'h0002 for 10 edges → no `vote_done`, all tallies 0.
- **Saturation and reset:** with CNT_W=2, four ballots for candidate 3 → tally 3 reads 3 and `total_votes`=4. Asserting `rst` mid-CAPTURE → IDLE with all counts 0.
